// File: rtl/prbs_sym_checker.sv
// Receive-side checker for the x^22 + x^21 + 1 PRBS symbol stream.
// It self-synchronises a local generator copy from the I LSB, then
// free-runs it as a flywheel. While locked it counts symbol errors per
// measurement window and drops lock on excessive errors per block.
module prbs_sym_checker #(
  parameter int unsigned WINDOW      = 4194303,
  parameter int unsigned BLOCK_LEN   = 256,
  parameter int unsigned LOSS_THRESH = 32
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        sam_clk_ena,
  input  logic        clear,
  input  logic [1:0]  I_sym_in,
  input  logic [1:0]  Q_sym_in,
  output logic        locked,
  output logic [21:0] err_count,
  output logic [21:0] err_total,
  output logic        meas_done,
  output logic [7:0]  lock_loss_cnt
);

  localparam int unsigned BLK_W = $clog2(BLOCK_LEN + 1);
  localparam int unsigned ERR_W = $clog2(LOSS_THRESH + 1);

  localparam logic [21:0]      WIN_LAST = 22'(WINDOW - 1);
  localparam logic [BLK_W-1:0] BLK_LAST = BLK_W'(BLOCK_LEN - 1);
  localparam logic [ERR_W:0]   THRESH   = (ERR_W + 1)'(LOSS_THRESH);

  typedef enum logic {ACQUIRE, CHECK} state_t;

  state_t           state;
  logic [21:0]      r;
  logic [4:0]       acq_cnt;
  logic [21:0]      sym_count;
  logic [BLK_W-1:0] blk_cnt;
  logic [ERR_W-1:0] blk_err;

  logic             pred;
  logic [3:0]       exp_sym;
  logic             sym_err;
  logic [21:0]      r_acq;
  logic [21:0]      r_fly;
  logic [ERR_W:0]   err_sum;
  logic             loss;
  logic             win_end;
  logic             blk_end;
  logic [21:0]      err_inc;

  // Prediction, symbol compare and next-value helpers
  always_comb begin
    pred    = r[21] ^ r[20];
    exp_sym = {r[2:0], pred};
    sym_err = (exp_sym != {Q_sym_in, I_sym_in});
    r_acq   = {r[20:0], I_sym_in[0]};
    r_fly   = {r[20:0], pred};
    err_sum = {1'b0, blk_err} + {{ERR_W{1'b0}}, sym_err};
    loss    = (err_sum >= THRESH);
    win_end = (sym_count == WIN_LAST);
    blk_end = (blk_cnt == BLK_LAST);
    err_inc = (err_count == '1) ? err_count : err_count + 22'(sym_err);
  end

  // Acquire/check state machine with all counters and registered outputs
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state         <= ACQUIRE;
      r             <= '0;
      acq_cnt       <= '0;
      sym_count     <= '0;
      blk_cnt       <= '0;
      blk_err       <= '0;
      locked        <= 1'b0;
      err_count     <= '0;
      err_total     <= '0;
      meas_done     <= 1'b0;
      lock_loss_cnt <= '0;
    end else if (clear) begin
      state         <= ACQUIRE;
      r             <= '0;
      acq_cnt       <= '0;
      sym_count     <= '0;
      blk_cnt       <= '0;
      blk_err       <= '0;
      locked        <= 1'b0;
      err_count     <= '0;
      err_total     <= '0;
      meas_done     <= 1'b0;
      lock_loss_cnt <= '0;
    end else begin
      meas_done <= 1'b0;
      if (sam_clk_ena) begin
        case (state)
          ACQUIRE: begin
            r <= r_acq;
            if (acq_cnt == 5'd21) begin
              acq_cnt <= '0;
              // All-zero is the LFSR lockup state; keep acquiring
              if (r_acq != '0) begin
                state  <= CHECK;
                locked <= 1'b1;
              end
            end else begin
              acq_cnt <= acq_cnt + 5'd1;
            end
          end
          CHECK: begin
            r <= r_fly;
            if (loss) begin
              // Loss of lock beats window end; the triggering symbol is dropped
              state     <= ACQUIRE;
              locked    <= 1'b0;
              acq_cnt   <= '0;
              err_count <= '0;
              sym_count <= '0;
              blk_cnt   <= '0;
              blk_err   <= '0;
              if (lock_loss_cnt != '1)
                lock_loss_cnt <= lock_loss_cnt + 8'd1;
            end else begin
              if (blk_end) begin
                blk_cnt <= '0;
                blk_err <= '0;
              end else begin
                blk_cnt <= blk_cnt + 1'b1;
                blk_err <= err_sum[ERR_W-1:0];
              end
              if (win_end) begin
                err_total <= err_inc;
                meas_done <= 1'b1;
                err_count <= '0;
                sym_count <= '0;
              end else begin
                err_count <= err_inc;
                sym_count <= sym_count + 22'd1;
              end
            end
          end
          default: state <= ACQUIRE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_prbs_sym_checker.sv
// Directed bench for prbs_sym_checker: table of stimulus phases with
// hand-derived expected outputs, plus hand sequences for clear and lockup.
module tb_prbs_sym_checker;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        sam_clk_ena = 1'b0;
  logic        clear = 1'b0;
  logic [1:0]  I_sym_in = '0;
  logic [1:0]  Q_sym_in = '0;
  logic        locked;
  logic [21:0] err_count;
  logic [21:0] err_total;
  logic        meas_done;
  logic [7:0]  lock_loss_cnt;

  prbs_sym_checker #(.WINDOW(1000), .BLOCK_LEN(256), .LOSS_THRESH(32)) dut (
    .clk(clk), .reset_n(reset_n), .sam_clk_ena(sam_clk_ena), .clear(clear),
    .I_sym_in(I_sym_in), .Q_sym_in(Q_sym_in), .locked(locked),
    .err_count(err_count), .err_total(err_total), .meas_done(meas_done),
    .lock_loss_cnt(lock_loss_cnt)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int md_pulses = 0;
  logic md_prev = 1'b0;
  logic [21:0] g = 22'h3fffff;

  // mode: 0 clean, 1 flip Q[1], 2 invert I[0], 3 all-zero, 4 idle clock
  typedef struct {
    int n; int mode; int lk; int cnt; int tot; int loss; int md;
  } step_t;
  step_t tbl[17];

  task automatic chk(input string name, input int act, input int exp_v);
    checks++;
    if (act != exp_v) begin
      errors++;
      $display("FAIL %s actual=%0d expected=%0d", name, act, exp_v);
    end
  endtask

  task automatic strobe(input int mode);
    logic [3:0] s;
    repeat (3) @(negedge clk);
    @(negedge clk);
    if (mode == 4) begin
      I_sym_in = 2'($urandom);
      Q_sym_in = 2'($urandom);
      sam_clk_ena = 1'b0;
    end else begin
      g = {g[20:0], g[21] ^ g[20]};
      s = g[3:0];
      if (mode == 1) s[3] = ~s[3];
      if (mode == 2) s[0] = ~s[0];
      if (mode == 3) s = '0;
      {Q_sym_in, I_sym_in} = s;
      sam_clk_ena = 1'b1;
    end
    @(posedge clk);
    #1;
    sam_clk_ena = 1'b0;
  endtask

  task automatic check_all(input string tag, input int lk, input int cnt,
                           input int tot, input int loss, input int md);
    chk({tag, ".locked"}, int'(locked), lk);
    chk({tag, ".err_count"}, int'(err_count), cnt);
    chk({tag, ".err_total"}, int'(err_total), tot);
    chk({tag, ".lock_loss_cnt"}, int'(lock_loss_cnt), loss);
    chk({tag, ".meas_done"}, int'(meas_done), md);
  endtask

  // meas_done must be a single-clock pulse
  always @(negedge clk) begin
    if (meas_done) begin
      md_pulses++;
      if (md_prev) begin
        errors++;
        $display("FAIL meas_done_width actual=2+ expected=1");
      end
    end
    md_prev = meas_done;
  end

  initial begin
    tbl[0]  = '{21,   0, 0, 0,  0, 0, 0};
    tbl[1]  = '{1,    0, 1, 0,  0, 0, 0};
    tbl[2]  = '{999,  0, 1, 0,  0, 0, 0};
    tbl[3]  = '{1,    0, 1, 0,  0, 0, 1};
    tbl[4]  = '{10,   0, 1, 0,  0, 0, 0};
    tbl[5]  = '{1,    1, 1, 1,  0, 0, 0};
    tbl[6]  = '{50,   4, 1, 1,  0, 0, 0};
    tbl[7]  = '{988,  0, 1, 1,  0, 0, 0};
    tbl[8]  = '{1,    0, 1, 0,  1, 0, 1};
    tbl[9]  = '{1000, 0, 1, 0,  0, 0, 1};
    tbl[10] = '{72,   0, 1, 0,  0, 0, 0};
    tbl[11] = '{31,   2, 1, 31, 0, 0, 0};
    tbl[12] = '{1,    2, 0, 0,  0, 1, 0};
    tbl[13] = '{21,   0, 0, 0,  0, 1, 0};
    tbl[14] = '{1,    0, 1, 0,  0, 1, 0};
    tbl[15] = '{3,    0, 1, 0,  0, 1, 0};
    tbl[16] = '{5,    1, 1, 5,  0, 1, 0};

    // Reset and idle
    repeat (5) @(negedge clk);
    check_all("reset", 0, 0, 0, 0, 0);
    reset_n = 1'b1;
    repeat (10) @(negedge clk);
    check_all("idle", 0, 0, 0, 0, 0);

    // Table-driven phases
    for (int i = 0; i < 17; i++) begin
      for (int j = 0; j < tbl[i].n; j++) strobe(tbl[i].mode);
      check_all($sformatf("step%0d", i), tbl[i].lk, tbl[i].cnt, tbl[i].tot,
                tbl[i].loss, tbl[i].md);
    end

    // Clear coincident with a strobe: clear wins, everything zero
    @(negedge clk);
    clear = 1'b1;
    sam_clk_ena = 1'b1;
    @(posedge clk);
    #1;
    clear = 1'b0;
    sam_clk_ena = 1'b0;
    check_all("clear", 0, 0, 0, 0, 0);

    // Relock after clear takes 22 strobes
    for (int j = 0; j < 21; j++) strobe(0);
    chk("relock21.locked", int'(locked), 0);
    strobe(0);
    chk("relock22.locked", int'(locked), 1);

    // Clear again, then all-zero data must never lock
    @(negedge clk);
    clear = 1'b1;
    @(posedge clk);
    #1;
    clear = 1'b0;
    chk("clear2.locked", int'(locked), 0);
    for (int j = 0; j < 100; j++) begin
      strobe(3);
      chk($sformatf("lockup%0d.locked", j), int'(locked), 0);
    end
    chk("lockup.err_count", int'(err_count), 0);

    repeat (4) @(negedge clk);
    chk("meas_done_pulses", md_pulses, 3);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/prbs_sym_checker.md
# prbs_sym_checker

Receive-side companion to the 22-bit PRBS symbol source (x^22 + x^21 + 1, seed 22'h3fffff, one new bit per sample). It sits after the QAM slicer and takes the decided 2-bit I and Q symbols at the sample rate. It self-synchronises a local copy of the generator and then free-runs it as a flywheel. While locked it counts symbol errors over a fixed measurement window, giving the team a hardware SER/BER figure for the modem chain.

## Interface
- WINDOW, 4194303: symbols per measurement window (one full PRBS period); range 2..4194303.
- BLOCK_LEN, 256: symbols per loss-of-lock evaluation block.
- LOSS_THRESH, 32: symbol errors within one block that force re-acquisition.
- clk  in  1  system clock; all logic on posedge.
- reset_n  in  1  asynchronous, active-low reset.
- sam_clk_ena  in  1  one-cycle sample strobe; all state advances only on cycles where it is high.
- clear  in  1  synchronous; returns FSM to ACQUIRE and zeroes all counters and outputs (same values as reset); has priority over sam_clk_ena.
- I_sym_in  in  2  sliced I symbol; bit 0 is the newest PRBS bit.
- Q_sym_in  in  2  sliced Q symbol; PRBS bits 3:2 of the generator register.
- locked  out  1  high while FSM in CHECK.
- err_count  out  22  running symbol-error count in current window, saturates at 22'h3fffff.
- err_total  out  22  err_count latched at window end.
- meas_done  out  1  one-cycle pulse when err_total updates.
- lock_loss_cnt  out  8  number of CHECK->ACQUIRE transitions, saturates at 255.

## Operation
- Local register r[21:0]. Expected new bit pred = r[21]^r[20]. Expected symbol exp = {r[2:0], pred}; compare to {Q_sym_in, I_sym_in}. Any mismatch on the 4 bits is one symbol error (sym_err).
- States:
  - ACQUIRE (reset state)
    - Each strobe: r <= {r[20:0], I_sym_in[0]}; acq_cnt <= acq_cnt+1.
    - On the strobe where acq_cnt reaches 22: if the new r value is nonzero, go to CHECK with acq_cnt=0. If it is all-zero, stay in ACQUIRE with acq_cnt=0; all-zero is the LFSR lockup state.
    - No error counting in this state.
  - CHECK
    - Each strobe: r <= {r[20:0], pred} (flywheel: received bits never enter r, so one error does not propagate).
    - sym_count, blk_cnt and blk_err advance. err_count increments on sym_err, saturating.
- Window end: on the strobe where sym_count reaches WINDOW:
  - err_total <= err_count + sym_err (saturating); meas_done pulses.
  - err_count and sym_count restart at 0 on the next cycle.
- Block evaluation:
  - At the end of each BLOCK_LEN-symbol block, blk_err clears.
  - If blk_err + sym_err reaches LOSS_THRESH at any strobe, go to ACQUIRE that cycle.
  - On that transition: lock_loss_cnt increments, err_count and sym_count clear, and err_total holds its value.
  - The symbol that triggers loss of lock is not counted.
- Simultaneous window end and loss of lock: loss of lock wins; no meas_done.
- Reset or clear mid-CHECK: immediate ACQUIRE, all outputs zero.

## Timing
- Reset values: locked=0, err_count=0, err_total=0, meas_done=0, lock_loss_cnt=0, r=0, state ACQUIRE.
- All outputs are registered; they reflect a strobe one clk after the strobe edge.
- With generator and checker connected directly, locked rises one clk after the 22nd strobe following reset release.
- meas_done is high for exactly one clk and is never asserted while sam_clk_ena is low.
- Inputs are sampled only on strobe cycles. Between strobes all state holds.

## Test plan
- Reset/idle: hold reset_n low, then release with no strobes -> all outputs 0 and locked stays 0.
- Clean lock: drive I/Q from generator model seeded 22'h3fffff, strobe every 4 clk, WINDOW=1000 -> locked after 22nd strobe; meas_done after strobe 1022 with err_total=0; repeats every 1000 strobes.
- Single error: flip Q_sym_in[1] on one CHECK strobe -> err_count=1, next window err_total=1 then 0 thereafter; locked stays 1.
- Burst loss: invert I_sym_in[0] on 32 consecutive strobes -> locked falls after the 32nd; lock_loss_cnt=1; relocks 22 strobes after clean data resumes.
- Lockup guard: drive all-zero symbols for 100 strobes -> locked never rises.
- Mid-operation reset/clear: assert clear during CHECK with err_count=5 -> next cycle all outputs 0, ACQUIRE, relock after 22 strobes. Strobe gap of 50 clk during CHECK -> no counter change.
